riscv_dmem_responder: RTL and testbench

RISCV_DMEM_RESPONDER -- requirements
Module: riscv_dmem_responder

---
 rtl/riscv_dmem_responder.sv | 90 +++++++++
 tb/tb_riscv_dmem_responder.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/riscv_dmem_responder.sv
// riscv_dmem_responder: single-outstanding data memory slave with fixed response latency.
// Ports: clk, a_rst (async, active-high); req_i/we_i/addr_i/wdata_i/be_i request;
//        gnt_o accept; rvalid_o/rdata_o/err_o one-cycle response.
// Optional: define RISCV_DMEM_BE_CHECK_EN to reject illegal byte-enable patterns with err_o.
`timescale 1ns/1ps
module riscv_dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        a_rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = LATENCY > 0 ? 4'(LATENCY - 1) : 4'd0;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t        r_state, w_next;
    logic [3:0]    r_cnt, w_cnt_next;
    logic          r_rdy;
    logic [31:0]   r_rdata;
    logic [31:0]   r_mem [DEPTH_WORDS];
    logic [AW-1:0] w_idx;
    logic          w_acc, w_legal, w_unused;
    assign w_idx    = addr_i[AW+1:2];
    assign w_unused = ^{addr_i[31:AW+2], addr_i[1:0]};
    // r_rdy holds grant low until the first edge after reset release
    assign gnt_o    = r_rdy && r_state == IDLE;
    assign w_acc    = req_i && gnt_o;
    assign rvalid_o = r_state == RESP;
    assign rdata_o  = rvalid_o ? r_rdata : '0;
`ifdef RISCV_DMEM_BE_CHECK_EN
    logic r_err;
    assign w_legal = be_i inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    assign err_o   = rvalid_o && r_err;
`else
    assign w_legal = 1'b1;
    assign err_o   = 1'b0;
`endif
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rdy   <= 1'b0;
            r_rdata <= '0;
`ifdef RISCV_DMEM_BE_CHECK_EN
            r_err   <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_rdy   <= 1'b1;
            if (w_acc) begin
                r_rdata <= (we_i || !w_legal) ? '0 : r_mem[w_idx];
`ifdef RISCV_DMEM_BE_CHECK_EN
                r_err   <= !w_legal;
`endif
            end
        end
    end
    // Array is never reset; stores commit at the accepting edge
    always_ff @(posedge clk) begin
        if (w_acc && we_i && w_legal)
            for (int n = 0; n < 4; n++)
                if (be_i[n]) r_mem[w_idx][8*n +: 8] <= wdata_i[8*n +: 8];
    end
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            IDLE: if (w_acc) begin
                w_next     = (LATENCY > 0) ? WAIT : RESP;
                w_cnt_next = CNT_INIT;
            end
            WAIT: begin
                w_next     = (r_cnt == 4'd0) ? RESP : WAIT;
                w_cnt_next = (r_cnt == 4'd0) ? r_cnt : r_cnt - 4'd1;
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_riscv_dmem_responder.sv
// tb_riscv_dmem_responder: directed scoreboard bench for riscv_dmem_responder.
`timescale 1ns/1ps
module tb_riscv_dmem_responder;
    localparam int LAT = 2;
    logic        clk = 1'b0, a_rst = 1'b1, req_i = 1'b0, we_i = 1'b0;
    logic [31:0] addr_i = '0, wdata_i = '0;
    logic [3:0]  be_i = '0;
    logic        gnt_o, rvalid_o, err_o;
    logic [31:0] rdata_o;
    int          n_chk = 0, n_fail = 0;
    logic [32:0] sb [$];
`ifdef RISCV_DMEM_BE_CHECK_EN
    localparam logic BE_ERR = 1'b1;
`else
    localparam logic BE_ERR = 1'b0;
`endif

    riscv_dmem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT)) dut (
        .clk(clk), .a_rst(a_rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
        .rdata_o(rdata_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic xact(input string tag, input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input logic [31:0] exp_d, input logic exp_e);
        int k;
        logic [32:0] e;
        @(negedge clk);
        req_i = 1'b1; we_i = we; addr_i = a; wdata_i = wd; be_i = be;
        k = 0;
        while (!gnt_o && k < 20) begin @(negedge clk); k++; end
        check({tag, "_gnt"}, 32'(gnt_o), 32'd1);
        @(posedge clk);
        sb.push_back({exp_e, exp_d});
        #1 req_i = 1'b0; we_i = 1'b0; be_i = '0;
        k = 0;
        do begin @(negedge clk); k++; end while (!rvalid_o && k < 20);
        check({tag, "_lat"}, 32'(k), 32'(LAT + 1));
        e = sb.pop_front();
        if (rvalid_o) begin
            check({tag, "_rdata"}, rdata_o, e[31:0]);
            check({tag, "_err"}, 32'(err_o), 32'(e[32]));
        end
    endtask

    task automatic reset_mid(input string tag, input logic we, input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        req_i = 1'b1; we_i = we; addr_i = a; wdata_i = wd; be_i = 4'hF;
        @(posedge clk);
        #1 req_i = 1'b0; we_i = 1'b0;
        @(negedge clk);
        a_rst = 1'b1;
        #1;
        check({tag, "_rst_gnt"}, 32'(gnt_o), 32'd0);
        check({tag, "_rst_rvalid"}, 32'(rvalid_o), 32'd0);
        @(negedge clk);
        check({tag, "_rst_gnt2"}, 32'(gnt_o), 32'd0);
        check({tag, "_rst_rdata"}, rdata_o, 32'd0);
        a_rst = 1'b0;
        #1 check({tag, "_rel_gnt"}, 32'(gnt_o), 32'd0);
        @(negedge clk);
        check({tag, "_post_gnt"}, 32'(gnt_o), 32'd1);
        check({tag, "_post_rvalid"}, 32'(rvalid_o), 32'd0);
        repeat (4) begin
            @(negedge clk);
            check({tag, "_no_rvalid"}, 32'(rvalid_o), 32'd0);
        end
    endtask

    initial begin
        int g, v, ov, last;
        logic [32:0] e;
        repeat (2) @(negedge clk);
        check("rst_gnt", 32'(gnt_o), 32'd0);
        check("rst_rvalid", 32'(rvalid_o), 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        a_rst = 1'b0;
        #1 check("rel_gnt", 32'(gnt_o), 32'd0);
        @(negedge clk);
        check("first_gnt", 32'(gnt_o), 32'd1);

        xact("st10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
        xact("ld10", 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0);
        xact("st20", 1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0);
        xact("st20p", 1'b1, 32'h20, 32'h00AA0000, 4'b0100, 32'h0, 1'b0);
        xact("ld20", 1'b0, 32'h20, 32'h0, 4'hF, 32'h11AA3344, 1'b0);
        xact("st400", 1'b1, 32'h400, 32'h5A5A5A5A, 4'hF, 32'h0, 1'b0);
        xact("ld000", 1'b0, 32'h000, 32'h0, 4'hF, 32'h5A5A5A5A, 1'b0);
        xact("ld403", 1'b0, 32'h403, 32'h0, 4'hF, 32'h5A5A5A5A, 1'b0);
        xact("ldhi10", 1'b0, 32'hFFFF0010, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0);

        xact("st30", 1'b1, 32'h30, 32'h12345678, 4'hF, 32'h0, 1'b0);
        xact("st30_0101", 1'b1, 32'h30, 32'hAABBCCDD, 4'b0101, 32'h0, BE_ERR);
        xact("ld30", 1'b0, 32'h30, 32'h0, 4'hF, BE_ERR ? 32'h12345678 : 32'h12BB56DD, 1'b0);
        xact("st30_0000", 1'b1, 32'h30, 32'hFFFFFFFF, 4'b0000, 32'h0, BE_ERR);
        xact("ld30b", 1'b0, 32'h30, 32'h0, 4'hF, BE_ERR ? 32'h12345678 : 32'h12BB56DD, 1'b0);

        // Continuous request: one grant every LAT+2 cycles, one response per grant
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h10; be_i = 4'hF;
        g = 0; v = 0; ov = 0; last = -1;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            if (gnt_o && rvalid_o) ov++;
            if (gnt_o) begin
                if (last >= 0) check("b2b_gap", 32'(i - last), 32'(LAT + 2));
                last = i;
                g++;
                sb.push_back({1'b0, 32'hDEADBEEF});
            end
            if (rvalid_o) begin
                v++;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("b2b_rdata", rdata_o, e[31:0]);
                end else check("b2b_unexpected_rvalid", 32'd1, 32'd0);
            end
        end
        req_i = 1'b0;
        check("b2b_gnts", 32'(g), 32'd4);
        check("b2b_rvalids", 32'(v), 32'd4);
        check("b2b_overlap", 32'(ov), 32'd0);
        check("b2b_sb_empty", 32'(sb.size()), 32'd0);
        sb.delete();

        reset_mid("rld", 1'b0, 32'h10, 32'h0);
        reset_mid("rst", 1'b1, 32'h40, 32'h77665544);
        xact("ld40", 1'b0, 32'h40, 32'h0, 4'hF, 32'h77665544, 1'b0);
        xact("ld10_after", 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
